hamming_encoder_proj: RTL and testbench
=======================================

// Module: hamming_encoder_proj
// PURPOSE
//  Transmit-side counterpart of the 7-bit Hamming(7,4) decoder project.
//  - Accepts 4-bit data nibbles on a valid/ready interface and buffers them in a small FIFO.
//  - Encodes each nibble into a Hamming(7,4) codeword and presents it on a registered 7-bit io_out with valid/ready.
//  - Counts transmitted codewords.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  CNT_W   16  width of tx_count; wraps modulo 2**CNT_W
// PORTS
//  clock      in   1      single clock, all logic on posedge
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      FIFO can accept (not full)
//  in_data    in   4      data nibble d[3:0]
//  out_valid  out  1      io_out holds a codeword
//  out_ready  in   1      sink accepts io_out this cycle
//  io_out     out  7      codeword
//  tx_count   out  CNT_W  codewords handed off (out_valid&&out_ready)
//  inj_en     in   1      error-inject enable (used only with macro)
//  inj_pos    in   3      bit to flip, 1..7 => io_out[inj_pos-1]; 0 = none
// BEHAVIOUR
//  Reset (async assert, sync deassert by the parent): all outputs 0 except in_ready.
//   - FIFO empty; rd/wr ptrs 0; output FSM=EMPTY; io_out=7'b0; out_valid=0; tx_count=0.
//   - in_ready=1 as soon as reset is released.
//  Encoding, with d0=in_data[0]:
//   - p0=d0^d1^d3; p1=d0^d2^d3; p2=d1^d2^d3.
//   - io_out = {d3,d2,d1,p2,d0,p1,p0} (Hamming positions 7..1).
//  Input handshake:
//   - Write when in_valid&&in_ready; in_ready = !full.
//   - in_data is ignored when in_valid=0.
//  FIFO:
//   - Pointers are log2(DEPTH)+1 bits; full/empty from MSB compare.
//   - Simultaneous push and pop while full is not permitted (in_ready=0).
//   - Simultaneous push and pop while empty: the push lands in the FIFO; the pop is not possible.
//  Output FSM states: EMPTY, FULL.
//   - EMPTY & FIFO non-empty -> load encoded head into io_out, pop, go FULL.
//   - FULL & out_ready & FIFO non-empty -> reload from head, pop, stay FULL (back-to-back, 1 word/cycle).
//   - FULL & out_ready & FIFO empty -> go EMPTY, out_valid=0.
//   - FULL & !out_ready -> hold; io_out and out_valid stable.
//  Latency: nibble accepted at edge N is on io_out after edge N+1 (minimum 2 edges), when FIFO and output reg are empty.
//  tx_count increments on every out_valid&&out_ready and wraps to 0 after 2**CNT_W-1.
//  Reset mid-operation: FIFO contents are discarded, and the word in flight is lost without a count.
// CONFIGURATION
//  HAMMING_ENC_ERR_INJECT_EN defined:
//   - On load into io_out, if inj_en && inj_pos!=0, bit inj_pos-1 of the codeword is inverted.
//   - inj_en/inj_pos are sampled at load time only.
//  Undefined: inj_en/inj_pos are ignored, and io_out is always the clean codeword.
// STRUCTURE
//  Package hamming_proj_pkg:
//   - CW_W=7, DATA_W=4.
//   - function hamming74_enc(d) -> codeword.
//   - Output FSM state typedef {EMPTY, FULL}; shared with the decoder project.
//  Sub-module hamming_enc_fifo: DEPTH x 4 sync FIFO with push/pop/full/empty.
//  Top: encoder function, output FSM/register, counter, inject logic.
// TESTING
//  1 Reset, then push d=4'b0001, out_ready=1 -> io_out=7'b0000111 two edges later, tx_count=1.
//  2 Push d=4'b1011 -> io_out=7'b1010101; push 4'b0000 -> io_out=7'b0000000.
//  3 out_ready=0, push 5 nibbles with DEPTH=4:
//     - 1 in output reg + 4 in FIFO; in_ready=0 after the 5th.
//     - Release out_ready -> 5 codewords in order, back-to-back, tx_count=5.
//  4 Drive reset_n low mid-stream while FULL:
//     - out_valid, io_out and tx_count go to 0 immediately (async).
//     - in_ready=1 after release.
//  5 Preload tx_count near 2**CNT_W-1 (CNT_W=4 build), send 2 words -> count wraps 15->0->1.
//  6 With HAMMING_ENC_ERR_INJECT_EN, inj_en=1, inj_pos=3, d=4'b1011 -> io_out=7'b1010001.
//     - Decoder corrects it back to 4'b1011.
//     - Without the macro, io_out=7'b1010101.

Source files
------------

// File: rtl/hamming_proj_pkg.sv
// Shared definitions for the Hamming(7,4) encoder/decoder project.
//   CW_W, DATA_W    : codeword and data widths
//   out_state_e     : output-register FSM state, shared with the decoder
//   hamming74_enc() : data nibble -> codeword {d3,d2,d1,p2,d0,p1,p0}
package hamming_proj_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Bit i of the result is Hamming position i+1; parity bits sit at 1, 2, 4.
  function automatic logic [CW_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
    logic p0, p1, p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_fifo.sv
// DEPTH x DATA_W synchronous FIFO feeding the encoder output register.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, push_data: write one entry (caller guarantees !full)
//   pop            : drop the head entry (caller guarantees !empty)
//   head_data      : current head entry, valid while !empty
//   full, empty    : occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// that differ only in the wrap bit mean full.
module hamming_enc_fifo
  import hamming_proj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/hamming_encoder_proj.sv
// Hamming(7,4) transmit side: buffers nibbles in a FIFO, encodes the head
// into a registered codeword and counts codewords handed to the sink.
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data = d[3:0]
//   out_valid/out_ready : output handshake, io_out = codeword
//   tx_count            : codewords handed off, wraps modulo 2**CNT_W
//   inj_en, inj_pos     : error injection, active only with the
//                         HAMMING_ENC_ERR_INJECT_EN macro defined
//   dbg_state           : output FSM state
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and data stable until then, and the output side
// keeps io_out/out_valid stable while out_ready is low.
module hamming_encoder_proj
  import hamming_proj_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   io_out,
  output logic [CNT_W-1:0]  tx_count,
  input  logic              inj_en,
  input  logic [2:0]        inj_pos,
  output out_state_e        dbg_state
);

  out_state_e        state_q, state_d;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head_data;
  logic              push, load;
  logic [CW_W-1:0]   cw_load;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign dbg_state = state_q;

  hamming_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_data),
    .pop       (load),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [CW_W-1:0] inj_mask;
  assign inj_mask = (inj_en && (inj_pos != 3'd0)) ? (CW_W'(1) << (inj_pos - 3'd1)) : '0;
  assign cw_load  = hamming74_enc(head_data) ^ inj_mask;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_pos};
  assign cw_load    = hamming74_enc(head_data);
`endif

  // A load pops the FIFO head into the output register; the pop only ever
  // happens when the FIFO holds something, so a push into an empty FIFO
  // simply lands there.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (!fifo_empty) load    = 1'b1;
          else             state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      io_out   <= '0;
      tx_count <= '0;
    end else begin
      state_q <= state_d;
      if (load)                   io_out   <= cw_load;
      if (out_valid && out_ready) tx_count <= tx_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_encoder_proj.sv
module tb_hamming_encoder_proj;
  import hamming_proj_pkg::*;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = 4'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [6:0]       io_out;
  logic [CNT_W-1:0] tx_count;
  logic             inj_en = 1'b0;
  logic [2:0]       inj_pos = 3'd0;
  out_state_e       dbg_state;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  hamming_encoder_proj #(.DEPTH(4), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .io_out    (io_out),
    .tx_count  (tx_count),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Positional model: bit i is position i+1; parity at positions 1,2,4.
  function automatic logic [6:0] enc_model(input logic [3:0] d);
    logic [6:0] c;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int k = 0; k < 3; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (pos[k] && (pos != (1 << k))) p = p ^ c[pos-1];
      c[(1 << k) - 1] = p;
    end
    return c;
  endfunction

  // Single-error-correcting decode of a received codeword.
  function automatic logic [3:0] dec_model(input logic [6:0] cw);
    logic [2:0] s;
    logic [6:0] c;
    c = cw;
    s = '0;
    for (int pos = 1; pos <= 7; pos++)
      if (c[pos-1]) s = s ^ pos[2:0];
    if (s != 3'd0) c[s-3'd1] = ~c[s-3'd1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // scoreboard: every handoff must match the head of exp_q
  always @(posedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_word", {25'd0, io_out}, 32'hffff_ffff);
      else check_eq("word", {25'd0, io_out}, {25'd0, exp_q.pop_front()});
    end
  end

  // driver: called just after a negedge, returns just after a negedge
  task automatic push_nib(input logic [3:0] d, input logic [6:0] exp_cw);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check_eq("push_timeout", 32'(n), 32'd0);
    else exp_q.push_back(exp_cw);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 4'hx;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [6:0] exp6;

    // reset state
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_io_out", {25'd0, io_out}, 32'd0);
    check_eq("rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_state", 32'(dbg_state), 32'(EMPTY));
    @(negedge clock);
    reset_n = 1'b1;

    // 1: single word, latency 2 edges
    out_ready = 1'b1;
    push_nib(4'b0001, 7'b0000111);
    check_eq("t1_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_io_out", {25'd0, io_out}, 32'b0000111);
    check_eq("t1_state", 32'(dbg_state), 32'(FULL));
    @(negedge clock);
    check_eq("t1_count", 32'(tx_count), 32'd1);
    check_eq("t1_idle", 32'(out_valid), 32'd0);

    // 2: two more patterns
    push_nib(4'b1011, 7'b1010101);
    push_nib(4'b0000, 7'b0000000);
    drain("t2_drain");
    check_eq("t2_count", 32'(tx_count), 32'd3);

    // 3: fill with sink stalled, then release
    out_ready = 1'b0;
    push_nib(4'b0011, 7'b0011110);
    push_nib(4'b0101, 7'b0101101);
    push_nib(4'b1001, 7'b1001100);
    push_nib(4'b1110, 7'b1111000);
    push_nib(4'b0111, 7'b0110100);
    check_eq("t3_in_ready_full", 32'(in_ready), 32'd0);
    check_eq("t3_head", {25'd0, io_out}, 32'b0011110);
    repeat (3) @(negedge clock);
    check_eq("t3_hold_io", {25'd0, io_out}, 32'b0011110);
    check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
    check_eq("t3_hold_count", 32'(tx_count), 32'd3);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq("t3_b2b_cycles", 32'(n), 32'd5);
    check_eq("t3_count", 32'(tx_count), 32'd8);
    check_eq("t3_empty", 32'(out_valid), 32'd0);

    // 4: async reset while FULL with more data queued
    out_ready = 1'b0;
    push_nib(4'b0001, 7'b0000111);
    push_nib(4'b1011, 7'b1010101);
    check_eq("t4_full", 32'(dbg_state), 32'(FULL));
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t4_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t4_rst_io", {25'd0, io_out}, 32'd0);
    check_eq("t4_rst_count", 32'(tx_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("t4_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clock);
    check_eq("t4_fifo_discarded", 32'(out_valid), 32'd0);

    // 5: counter wrap (CNT_W=4): 15 words, then 2 more
    for (int i = 0; i < 15; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      push_nib(d, enc_model(d));
    end
    drain("t5_drain15");
    check_eq("t5_count15", 32'(tx_count), 32'd15);
    push_nib(4'b1100, enc_model(4'b1100));
    drain("t5_drain16");
    check_eq("t5_wrap0", 32'(tx_count), 32'd0);
    push_nib(4'b0110, enc_model(4'b0110));
    drain("t5_drain17");
    check_eq("t5_wrap1", 32'(tx_count), 32'd1);

    // 6: error injection at position 3
    do_reset();
`ifdef HAMMING_ENC_ERR_INJECT_EN
    exp6 = 7'b1010001;
`else
    exp6 = 7'b1010101;
`endif
    out_ready = 1'b0;
    inj_en  = 1'b1;
    inj_pos = 3'd3;
    push_nib(4'b1011, exp6);
    @(negedge clock);
    inj_en  = 1'b0;
    inj_pos = 3'd0;
    check_eq("t6_io_out", {25'd0, io_out}, {25'd0, exp6});
    check_eq("t6_decoded", 32'(dec_model(io_out)), 32'b1011);
    out_ready = 1'b1;
    push_nib(4'b1011, 7'b1010101);
    drain("t6_drain");
    check_eq("t6_count", 32'(tx_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
